wb_pipe_master: RTL and testbench

- Wishbone pipelined-mode bus initiator, 8-bit address and data.
- Converts a simple valid/ready command stream (from the CPU-side sequencer or a testbench) into wishbone cycles toward slaves such as the 8-bit ALU.
- Returns each acknowledged transfer as a one-cycle response pulse, in order.
- Bounds in-flight requests and aborts the cycle on a missing acknowledge.

---
 rtl/wb_pipe_master.sv | 130 +++++++++++++
 tb/tb_wb_pipe_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_master.sv
// Wishbone pipelined-mode initiator: turns a valid/ready command stream into bus
// requests and returns each acknowledge (or a timeout abort) as an in-order response pulse.
module wb_pipe_master #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [1:0]        state_q, state_d;
  logic              stb_q, stb_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [7:0]        tmr_q, tmr_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;

  logic             cyc, issue, accept, ack_ok, timeout;
  logic [CNT_W-1:0] pending;

  assign cyc     = (state_q == S_BUS);
  assign issue   = stb_q && !i_wb_stall;
  assign pending = out_q + CNT_W'(stb_q);
  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign o_cmd_ready = reset && (state_q != S_ABORT) &&
                       (pending < CNT_W'(MAX_OUTSTANDING)) && (!stb_q || !i_wb_stall);
  assign accept  = i_cmd_valid && o_cmd_ready;
  // A zero-latency ack is legal: it retires the request issuing this very cycle.
  assign ack_ok  = i_wb_ack && cyc && ((out_q != '0) || issue);
  assign timeout = cyc && (tmr_q == 8'(TIMEOUT - 1)) && !ack_ok;

  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q && i_wb_stall;
    req_d     = req_q;
    out_d     = out_q + CNT_W'(issue) - CNT_W'(ack_ok);
    tmr_d     = tmr_q;
    rsp_vld_d = ack_ok;
    rsp_err_d = 1'b0;
    rsp_dat_d = ack_ok ? i_wb_data : '0;
    if (accept) begin
      stb_d = 1'b1;
      req_d = '{we: i_cmd_we, addr: i_cmd_addr, data: i_cmd_data};
    end
    if (issue || ack_ok || (pending == '0)) tmr_d = '0;
    else if (cyc)                           tmr_d = tmr_q + 8'd1;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUS;
      S_BUS: begin
        if (timeout) begin
          // One error response stands in for every lost request.
          state_d   = S_ABORT;
          stb_d     = 1'b0;
          out_d     = '0;
          tmr_d     = '0;
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
        end else if (!stb_d && (out_d == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      stb_q     <= 1'b0;
      req_q     <= '0;
      out_q     <= '0;
      tmr_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_d;
      req_q     <= req_d;
      out_q     <= out_d;
      tmr_q     <= tmr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign o_wb_cyc    = cyc;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = req_q.we;
  assign o_wb_addr   = req_q.addr;
  assign o_wb_data   = req_q.data;
  assign o_rsp_valid = rsp_vld_q;
  assign o_rsp_data  = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_wb_pipe_master.sv
// Bench for wb_pipe_master: randomized slave (stall/latency) plus a queue-based
// transaction scoreboard, and directed timeout / stray-ack / reset scenarios.
module tb_wb_pipe_master;
  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic       i_clk = 1'b0, reset = 1'b0;
  logic       i_cmd_valid = 1'b0, i_cmd_we = 1'b0;
  logic [7:0] i_cmd_addr = '0, i_cmd_data = '0;
  logic       o_cmd_ready, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [7:0] o_wb_addr, o_wb_data, o_rsp_data;
  logic       i_wb_ack = 1'b0, i_wb_stall = 1'b0;
  logic [7:0] i_wb_data = '0;
  logic       o_rsp_valid, o_rsp_err;

  wb_pipe_master #(.ADDR_W(8), .DATA_W(8), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc_n = 0;
  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // ---------------- slave model ----------------
  typedef struct { logic [7:0] data; int due; } sreq_t;
  sreq_t      sq[$];
  logic [7:0] smem[256];
  int         lat_min = 1, lat_max = 1, stall_pct = 0, stall_left = 0;
  bit         sl_auto = 1'b1;
  logic       force_ack = 1'b0, force_stall = 1'b0;
  logic [7:0] force_data = '0;

  always @(negedge i_clk) begin
    sreq_t r;
    logic  stl;
    #1;
    if (!reset) begin
      sq.delete();
      i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
    end else if (!sl_auto) begin
      i_wb_ack = force_ack; i_wb_stall = force_stall; i_wb_data = force_data;
    end else begin
      if (o_wb_stb && stall_left > 0) begin
        stl = 1'b1;
        stall_left--;
      end else begin
        stl = o_wb_stb && ($urandom_range(99) < stall_pct);
      end
      if (o_wb_stb && !stl) begin
        r.data = o_wb_we ? o_wb_data : smem[o_wb_addr];
        if (o_wb_we) smem[o_wb_addr] = o_wb_data;
        r.due = cyc_n + int'($urandom_range(lat_max, lat_min));
        sq.push_back(r);
      end
      i_wb_stall = stl;
      i_wb_ack   = 1'b0;
      i_wb_data  = 8'($urandom);
      if (sq.size() > 0 && sq[0].due <= cyc_n) begin
        i_wb_ack  = 1'b1;
        i_wb_data = sq[0].data;
        void'(sq.pop_front());
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } cmd_t;
  typedef struct { int cyc; logic [7:0] data; } rsp_t;
  cmd_t       exp_req[$];
  logic [7:0] exp_dat[$];
  rsp_t       exp_rsp[$];
  logic [7:0] refmem[256];
  int         outst = 0;
  bit         mon_en = 1'b0;
  int         rsp_cyc_log[$];
  logic [7:0] rsp_dat_log[$];
  logic       rsp_err_log[$], rsp_wbc_log[$];
  int         cyc_rise = 0;
  logic       cyc_prev = 1'b0;

  always @(negedge i_clk) begin
    cmd_t c;
    rsp_t e;
    #4;
    if (!reset) begin
      exp_req.delete(); exp_dat.delete(); exp_rsp.delete();
      outst = 0; cyc_prev = 1'b0;
    end else begin
      if (o_wb_cyc && !cyc_prev) cyc_rise++;
      cyc_prev = o_wb_cyc;
      if (o_rsp_valid) begin
        rsp_cyc_log.push_back(cyc_n); rsp_dat_log.push_back(o_rsp_data);
        rsp_err_log.push_back(o_rsp_err); rsp_wbc_log.push_back(o_wb_cyc);
      end
      if (mon_en) begin
        if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc_n) begin
          e = exp_rsp.pop_front();
          chk("rsp_valid", o_rsp_valid, 1);
          chk("rsp_data", o_rsp_data, e.data);
          chk("rsp_err", o_rsp_err, 0);
        end else if (o_rsp_valid) begin
          chk("rsp_spurious", o_rsp_valid, 0);
        end
        if (i_cmd_valid && o_cmd_ready) begin
          chk("pending_bound", (outst + int'(o_wb_stb)) < MAXO, 1);
          c = '{i_cmd_we, i_cmd_addr, i_cmd_data};
          exp_req.push_back(c);
          if (c.we) refmem[c.addr] = c.data;
          exp_dat.push_back(c.we ? c.data : refmem[c.addr]);
        end
        if (o_wb_stb && !i_wb_stall) begin
          if (exp_req.size() == 0) chk("issue_unexpected", exp_req.size(), 1);
          else begin
            c = exp_req.pop_front();
            chk("req_we", o_wb_we, c.we);
            chk("req_addr", o_wb_addr, c.addr);
            if (c.we) chk("req_wdata", o_wb_data, c.data);
          end
          outst++;
        end
        if (i_wb_ack && o_wb_cyc && outst > 0 && exp_dat.size() > 0) begin
          outst--;
          e.cyc  = cyc_n + 1;
          e.data = exp_dat.pop_front();
          exp_rsp.push_back(e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d, output int t);
    int n = 0;
    i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = a; i_cmd_data = d;
    #4;
    while (!o_cmd_ready && n < 50) begin
      @(negedge i_clk); #4; n++;
    end
    if (!o_cmd_ready) chk("send_timeout", o_cmd_ready, 1);
    t = cyc_n;
    @(negedge i_clk);
  endtask

  task automatic wait_rsp(input int n0, output int t);
    int n = 0;
    while (rsp_cyc_log.size() <= n0 && n < 60) begin
      @(negedge i_clk); n++;
    end
    if (rsp_cyc_log.size() <= n0) begin
      chk("rsp_timeout", rsp_cyc_log.size(), n0 + 1);
      t = -1;
    end else begin
      t = rsp_cyc_log[n0];
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, tr, n0, r0;
    int acc, iss, last_iss, trsp;
    bit got;
    logic [7:0] g_dat;
    logic g_err, g_cyc, g_rdy;
    for (int i = 0; i < 256; i++) begin smem[i] = '0; refmem[i] = '0; end

    repeat (3) @(negedge i_clk);
    chk("reset_outputs", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
                          o_rsp_valid, o_rsp_data, o_rsp_err, o_cmd_ready}, 0);
    reset = 1'b1;
    @(negedge i_clk);
    mon_en = 1'b1;

    // write then read, one-cycle-ack slave
    n0 = rsp_cyc_log.size();
    send(1'b1, 8'h00, 8'h5A, t0); i_cmd_valid = 1'b0;
    wait_rsp(n0, tr);
    chk("wr_latency", tr - t0, 3);
    chk("wr_cyc_drop", rsp_wbc_log[n0], 0);
    send(1'b0, 8'h00, 8'h00, t0); i_cmd_valid = 1'b0;
    wait_rsp(n0 + 1, tr);
    chk("rd_latency", tr - t0, 3);
    chk("rd_data", rsp_dat_log[n0 + 1], 8'h5A);
    chk("rd_err", rsp_err_log[n0 + 1], 0);
    chk("rd_cyc_drop", rsp_wbc_log[n0 + 1], 0);

    // back-to-back reads
    n0 = rsp_cyc_log.size();
    send(1'b1, 8'h00, 8'h11, t0); i_cmd_valid = 1'b0; wait_rsp(n0, tr);
    send(1'b1, 8'h01, 8'h22, t0); i_cmd_valid = 1'b0; wait_rsp(n0 + 1, tr);
    n0 = rsp_cyc_log.size(); r0 = cyc_rise;
    send(1'b0, 8'h00, 8'h00, t0);
    send(1'b0, 8'h01, 8'h00, t1);
    send(1'b0, 8'h00, 8'h00, t2);
    i_cmd_valid = 1'b0;
    wait_rsp(n0 + 2, tr);
    chk("b2b_accept01", t1 - t0, 1);
    chk("b2b_accept12", t2 - t1, 1);
    chk("b2b_rsp01", rsp_cyc_log[n0 + 1] - rsp_cyc_log[n0], 1);
    chk("b2b_rsp12", rsp_cyc_log[n0 + 2] - rsp_cyc_log[n0 + 1], 1);
    chk("b2b_d0", rsp_dat_log[n0], 8'h11);
    chk("b2b_d1", rsp_dat_log[n0 + 1], 8'h22);
    chk("b2b_d2", rsp_dat_log[n0 + 2], 8'h11);
    chk("b2b_single_cyc", cyc_rise - r0, 1);
    repeat (2) @(negedge i_clk);

    // stall held 3 cycles on the first request
    n0 = rsp_cyc_log.size();
    stall_left = 3;
    send(1'b0, 8'h01, 8'hC3, t0); i_cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk("st_stb", o_wb_stb, 1);
      chk("st_addr", o_wb_addr, 8'h01);
      chk("st_we", o_wb_we, 0);
      chk("st_data", o_wb_data, 8'hC3);
      chk("st_ready", o_cmd_ready, (k < 3) ? 1'b0 : 1'b1);
      @(negedge i_clk);
    end
    wait_rsp(n0, tr);
    repeat (4) @(negedge i_clk);
    chk("st_rsp_count", rsp_cyc_log.size(), n0 + 1);
    chk("st_rsp_data", rsp_dat_log[n0], 8'h22);

    // randomized traffic
    lat_min = 0; lat_max = 2; stall_pct = 20;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(3) != 0)
        send(1'($urandom), 8'($urandom_range(7)), 8'($urandom), t0);
      else begin
        i_cmd_valid = 1'b0; @(negedge i_clk);
      end
    end
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 100 && (exp_rsp.size() > 0 || o_wb_cyc); k++) @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    chk("rand_drain_rsp", exp_rsp.size(), 0);
    chk("rand_drain_req", exp_req.size(), 0);
    chk("rand_idle_cyc", o_wb_cyc, 0);
    lat_min = 1; lat_max = 1; stall_pct = 0;

    // slave never acks: bound then timeout abort
    mon_en = 1'b0; sl_auto = 1'b0; force_ack = 1'b0; force_stall = 1'b0;
    @(negedge i_clk);
    acc = 0; iss = 0; last_iss = 0; trsp = 0; got = 1'b0;
    g_dat = '1; g_err = 1'b0; g_cyc = 1'b1; g_rdy = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 8'h03;
    for (int k = 0; k < 40 && !got; k++) begin
      #4;
      if (i_cmd_valid && o_cmd_ready) acc++;
      if (o_wb_stb && !i_wb_stall) begin iss++; last_iss = cyc_n; end
      if (o_rsp_valid) begin
        got = 1'b1; trsp = cyc_n;
        g_dat = o_rsp_data; g_err = o_rsp_err; g_cyc = o_wb_cyc; g_rdy = o_cmd_ready;
        i_cmd_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    chk("to_accepts", acc, MAXO);
    chk("to_issues", iss, MAXO);
    chk("to_rsp_seen", got, 1);
    chk("to_latency", trsp - last_iss, TMO + 1);
    chk("to_err", g_err, 1);
    chk("to_data", g_dat, 0);
    chk("to_abort_cyc", g_cyc, 0);
    chk("to_abort_ready", g_rdy, 0);
    #4;
    chk("to_ready_after", o_cmd_ready, 1);
    chk("to_cyc_after", o_wb_cyc, 0);
    chk("to_rsp_once", o_rsp_valid, 0);
    @(negedge i_clk);

    // stray ack while idle
    n0 = rsp_cyc_log.size();
    force_ack = 1'b1; force_data = 8'hAB;
    repeat (2) @(negedge i_clk);
    force_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("stray_no_rsp", rsp_cyc_log.size(), n0);
    #4;
    chk("stray_ready", o_cmd_ready, 1);
    chk("stray_cyc", o_wb_cyc, 0);
    @(negedge i_clk);

    // reset in the middle of a 2-request burst
    sl_auto = 1'b1; mon_en = 1'b1; lat_min = 2; lat_max = 2;
    send(1'b0, 8'h00, 8'h3C, t0);
    send(1'b0, 8'h01, 8'h4B, t1);
    i_cmd_valid = 1'b0;
    n0 = rsp_cyc_log.size();
    #2; reset = 1'b0; #1;
    chk("rst_async_outputs", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
                              o_rsp_valid, o_rsp_data, o_rsp_err, o_cmd_ready}, 0);
    repeat (2) @(negedge i_clk);
    reset = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_no_rsp", rsp_cyc_log.size(), n0);
    lat_min = 1; lat_max = 1;
    send(1'b0, 8'h00, 8'h00, t0); i_cmd_valid = 1'b0;
    wait_rsp(n0, tr);
    chk("rst_rd_latency", tr - t0, 3);
    chk("rst_rd_data", rsp_dat_log[n0], refmem[0]);
    repeat (3) @(negedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
